// File: rtl/ctrl_pkg.sv
// Shared opcode/ALUOP encodings and the ID/EX control bundle type for the control stage.
// The JAL/JALR opcodes are only decoded when CTRL_JUMP_EN is defined.
package ctrl_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [2:0] ALUOP_MEM = 3'b000;
    localparam logic [2:0] ALUOP_R   = 3'b001;
    localparam logic [2:0] ALUOP_BR  = 3'b010;
    localparam logic [2:0] ALUOP_I   = 3'b111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic       valid;
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic [2:0] aluop;
        logic       muldiv;
        logic       jump;
        logic       illegal;
    } ctrl_bundle_t;

    // A bubble is all-zero, so regwrite/memwrite can never leak out of one.
    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct7 -> control bundle decode; an invalid ID slot decodes to a bubble.
// JAL/JALR decode is enabled by CTRL_JUMP_EN; otherwise they fall into the illegal path.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic         id_valid,
    input  logic [6:0]   id_opcode,
    input  logic [6:0]   id_funct7,
    output ctrl_bundle_t ctrl_o
);

    always_comb begin
        ctrl_o = CTRL_BUBBLE;
        if (id_valid) begin
            ctrl_o.valid = 1'b1;
            case (id_opcode)
                OP_R: begin
                    ctrl_o.regwrite = 1'b1;
                    ctrl_o.aluop    = ALUOP_R;
                    ctrl_o.muldiv   = (id_funct7 == FUNCT7_MULDIV);
                end
                OP_LD: begin
                    ctrl_o.alusrc   = 1'b1;
                    ctrl_o.memtoreg = 1'b1;
                    ctrl_o.regwrite = 1'b1;
                    ctrl_o.memread  = 1'b1;
                    ctrl_o.aluop    = ALUOP_MEM;
                end
                OP_SD: begin
                    ctrl_o.alusrc   = 1'b1;
                    ctrl_o.memwrite = 1'b1;
                    ctrl_o.aluop    = ALUOP_MEM;
                end
                OP_BEQ: begin
                    ctrl_o.branch = 1'b1;
                    ctrl_o.aluop  = ALUOP_BR;
                end
                OP_I: begin
                    ctrl_o.alusrc   = 1'b1;
                    ctrl_o.regwrite = 1'b1;
                    ctrl_o.aluop    = ALUOP_I;
                end
`ifdef CTRL_JUMP_EN
                OP_JAL: begin
                    ctrl_o.regwrite = 1'b1;
                    ctrl_o.jump     = 1'b1;
                end
                OP_JALR: begin
                    ctrl_o.alusrc   = 1'b1;
                    ctrl_o.regwrite = 1'b1;
                    ctrl_o.jump     = 1'b1;
                end
`endif
                default: ctrl_o.illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/pipe_ctrl_stage.sv
// ID/EX control register with load-use bubbles, flush, downstream hold and MUL/DIV occupancy.
// CTRL_JUMP_EN enables JAL/JALR decode; without it ex_jump stays 0 because the decoder never sets it.
module pipe_ctrl_stage
    import ctrl_pkg::*;
#(
    parameter int MULDIV_LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [6:0] id_opcode,
    input  logic [6:0] id_funct7,
    input  logic       hazard,
    input  logic       flush,
    input  logic       ex_stall,
    output logic       stall_o,
    output logic       ex_valid,
    output logic       ex_alusrc,
    output logic       ex_memtoreg,
    output logic       ex_regwrite,
    output logic       ex_memread,
    output logic       ex_memwrite,
    output logic       ex_branch,
    output logic [2:0] ex_aluop,
    output logic       ex_muldiv,
    output logic       ex_jump,
    output logic       ex_illegal
);

    localparam int CNT_W = $clog2(MULDIV_LAT + 1);
    localparam logic [CNT_W-1:0] BUSY_INIT = CNT_W'(MULDIV_LAT - 1);

    ctrl_bundle_t     dec_ctrl;
    ctrl_bundle_t     bundle_d, bundle_q;
    logic [CNT_W-1:0] busy_cnt_d, busy_cnt_q;
    logic             busy;

    ctrl_decode u_decode (
        .id_valid  (id_valid),
        .id_opcode (id_opcode),
        .id_funct7 (id_funct7),
        .ctrl_o    (dec_ctrl)
    );

    assign busy = (busy_cnt_q != '0);

    // Busy counter holds the number of extra EX cycles still owed to the MUL/DIV in EX.
    always_comb begin
        bundle_d   = bundle_q;
        busy_cnt_d = busy_cnt_q;
        if (flush) begin
            bundle_d   = CTRL_BUBBLE;
            busy_cnt_d = '0;
        end else if (ex_stall) begin
            bundle_d   = bundle_q;
        end else if (busy) begin
            busy_cnt_d = busy_cnt_q - 1'b1;
        end else if (hazard) begin
            bundle_d   = CTRL_BUBBLE;
        end else begin
            bundle_d   = dec_ctrl;
            busy_cnt_d = dec_ctrl.muldiv ? BUSY_INIT : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bundle_q   <= CTRL_BUBBLE;
            busy_cnt_q <= '0;
        end else begin
            bundle_q   <= bundle_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign stall_o     = hazard | ex_stall | busy;
    assign ex_valid    = bundle_q.valid;
    assign ex_alusrc   = bundle_q.alusrc;
    assign ex_memtoreg = bundle_q.memtoreg;
    assign ex_regwrite = bundle_q.regwrite;
    assign ex_memread  = bundle_q.memread;
    assign ex_memwrite = bundle_q.memwrite;
    assign ex_branch   = bundle_q.branch;
    assign ex_aluop    = bundle_q.aluop;
    assign ex_muldiv   = bundle_q.muldiv;
    assign ex_jump     = bundle_q.jump;
    assign ex_illegal  = bundle_q.illegal;

endmodule

// File: tb/tb_pipe_ctrl_stage.sv
// Self-checking bench for pipe_ctrl_stage: directed scenarios plus random traffic against a behavioural model.
// Honours CTRL_JUMP_EN in its expectations for JAL/JALR.
module tb_pipe_ctrl_stage;

    localparam int LAT = 4;

    // Expected EX vectors: {valid,alusrc,memtoreg,regwrite,memread,memwrite,branch,aluop[2:0],muldiv,jump,illegal}
    localparam logic [12:0] LD_V   = 13'b1111100_000_000;
    localparam logic [12:0] SD_V   = 13'b1100010_000_000;
    localparam logic [12:0] I_V    = 13'b1101000_111_000;
    localparam logic [12:0] R_V    = 13'b1001000_001_000;
    localparam logic [12:0] MUL_V  = 13'b1001000_001_100;
    localparam logic [12:0] BEQ_V  = 13'b1000001_010_000;
    localparam logic [12:0] JAL_V  = 13'b1001000_000_010;
    localparam logic [12:0] JALR_V = 13'b1101000_000_010;
    localparam logic [12:0] ILL_V  = 13'b1000000_000_001;

    logic clk = 1'b0;
    logic rst, id_valid, hazard, flush, ex_stall;
    logic [6:0] id_opcode, id_funct7;
    logic stall_o, ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch;
    logic [2:0] ex_aluop;
    logic ex_muldiv, ex_jump, ex_illegal;
    logic [12:0] dut_vec;

    int checks = 0;
    int errors = 0;

    // Model state: expected EX vector and total MUL/DIV EX cycles still to run (including the current one).
    logic [12:0] m_vec;
    int          m_rem;

    always #5 clk = ~clk;

    pipe_ctrl_stage #(.MULDIV_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct7(id_funct7),
        .hazard(hazard), .flush(flush), .ex_stall(ex_stall), .stall_o(stall_o),
        .ex_valid(ex_valid), .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_branch(ex_branch), .ex_aluop(ex_aluop), .ex_muldiv(ex_muldiv),
        .ex_jump(ex_jump), .ex_illegal(ex_illegal)
    );

    assign dut_vec = {ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite,
                      ex_branch, ex_aluop, ex_muldiv, ex_jump, ex_illegal};

    function automatic logic [12:0] ref_decode(input logic v, input logic [6:0] op, input logic [6:0] f7);
        if (!v) return 13'd0;
        case (op)
            7'b0110011: return (f7 == 7'b0000001) ? MUL_V : R_V;
            7'b0000011: return LD_V;
            7'b0100011: return SD_V;
            7'b1100011: return BEQ_V;
            7'b0010011: return I_V;
`ifdef CTRL_JUMP_EN
            7'b1101111: return JAL_V;
            7'b1100111: return JALR_V;
`endif
            default:    return ILL_V;
        endcase
    endfunction

    function automatic logic model_stall();
        return hazard | ex_stall | (m_rem > 1);
    endfunction

    task automatic drive(input logic v, input logic [6:0] op, input logic [6:0] f7,
                         input logic hz, input logic fl, input logic es);
        id_valid = v; id_opcode = op; id_funct7 = f7;
        hazard = hz; flush = fl; ex_stall = es;
        #1;
    endtask

    // Advance one clock, applying the stage rules to the model with the inputs seen at the edge.
    task automatic tick();
        logic [12:0] d;
        @(posedge clk);
        d = ref_decode(id_valid, id_opcode, id_funct7);
        if (rst) begin
            m_vec = 13'd0; m_rem = 0;
        end else if (flush) begin
            m_vec = 13'd0; m_rem = 0;
        end else if (ex_stall) begin
            m_vec = m_vec;
        end else if (m_rem > 1) begin
            m_rem = m_rem - 1;
        end else if (hazard) begin
            m_vec = 13'd0; m_rem = 0;
        end else begin
            m_vec = d;
            m_rem = d[2] ? LAT : 0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 7'b0000011, 7'd0, 1'b1, 1'b0, 1'b0);
        tick(); tick();
        checks++;
        if (dut_vec !== 13'd0) begin errors++; $display("FAIL reset_bundle got=%b exp=%b", dut_vec, 13'd0); end
        checks++;
        if (stall_o !== 1'b1) begin errors++; $display("FAIL reset_stall_hazard got=%b exp=1", stall_o); end
        drive(1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall_idle got=%b exp=0", stall_o); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_ld_sd();
        drive(1'b1, 7'b0000011, 7'd0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (dut_vec !== LD_V) begin errors++; $display("FAIL ld_bundle got=%b exp=%b", dut_vec, LD_V); end
        drive(1'b1, 7'b0100011, 7'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL ld_sd_stall got=%b exp=0", stall_o); end
        tick();
        checks++;
        if (dut_vec !== SD_V) begin errors++; $display("FAIL sd_bundle got=%b exp=%b", dut_vec, SD_V); end
    endtask

    task automatic test_hazard();
        drive(1'b1, 7'b0000011, 7'd0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (stall_o !== 1'b1) begin errors++; $display("FAIL hazard_stall got=%b exp=1", stall_o); end
        tick();
        checks++;
        if (dut_vec !== 13'd0) begin errors++; $display("FAIL hazard_bubble got=%b exp=%b", dut_vec, 13'd0); end
        drive(1'b1, 7'b0000011, 7'd0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (dut_vec !== LD_V) begin errors++; $display("FAIL hazard_ld_after got=%b exp=%b", dut_vec, LD_V); end
    endtask

    task automatic test_mul();
        drive(1'b1, 7'b0110011, 7'b0000001, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 7'b0010011, 7'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= LAT; k++) begin
            checks++;
            if (dut_vec !== MUL_V) begin errors++; $display("FAIL mul_hold cyc=%0d got=%b exp=%b", k, dut_vec, MUL_V); end
            checks++;
            if (stall_o !== (k < LAT)) begin errors++; $display("FAIL mul_stall cyc=%0d got=%b exp=%b", k, stall_o, (k < LAT)); end
            tick();
        end
        checks++;
        if (dut_vec !== I_V) begin errors++; $display("FAIL mul_next_load got=%b exp=%b", dut_vec, I_V); end
    endtask

    task automatic test_flush_mul();
        drive(1'b1, 7'b0110011, 7'b0000001, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 7'b0010011, 7'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 7'b0010011, 7'd0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 7'b0010011, 7'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dut_vec !== 13'd0) begin errors++; $display("FAIL flush_bubble got=%b exp=%b", dut_vec, 13'd0); end
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b exp=0", stall_o); end
        tick();
        checks++;
        if (dut_vec !== I_V) begin errors++; $display("FAIL flush_next_load got=%b exp=%b", dut_vec, I_V); end
    endtask

    task automatic test_exstall_mul();
        int occ;
        int c;
        drive(1'b1, 7'b0110011, 7'b0000001, 1'b0, 1'b0, 1'b0);
        tick();
        occ = 1;
        c = 1;
        while (ex_muldiv === 1'b1 && c < 20) begin
            drive(1'b1, 7'b0010011, 7'd0, 1'b0, 1'b0, (c == 2 || c == 3));
            tick();
            c++;
            if (ex_muldiv === 1'b1) occ++;
        end
        checks++;
        if (occ != LAT + 2) begin errors++; $display("FAIL exstall_occupancy got=%0d exp=%0d", occ, LAT + 2); end
        checks++;
        if (dut_vec !== I_V) begin errors++; $display("FAIL exstall_next_load got=%b exp=%b", dut_vec, I_V); end
        drive(1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_jump();
        logic [12:0] exp_jal, exp_jalr;
`ifdef CTRL_JUMP_EN
        exp_jal = JAL_V; exp_jalr = JALR_V;
`else
        exp_jal = ILL_V; exp_jalr = ILL_V;
`endif
        drive(1'b1, 7'b1101111, 7'd0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (dut_vec !== exp_jal) begin errors++; $display("FAIL jal_bundle got=%b exp=%b", dut_vec, exp_jal); end
        drive(1'b1, 7'b1100111, 7'd0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (dut_vec !== exp_jalr) begin errors++; $display("FAIL jalr_bundle got=%b exp=%b", dut_vec, exp_jalr); end
        drive(1'b1, 7'b1111111, 7'd0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (dut_vec !== ILL_V) begin errors++; $display("FAIL illegal_bundle got=%b exp=%b", dut_vec, ILL_V); end
    endtask

    task automatic test_random();
        logic [6:0] ops [8];
        logic [6:0] op, f7;
        ops = '{7'b0110011, 7'b0110011, 7'b0000011, 7'b0100011,
                7'b1100011, 7'b0010011, 7'b1101111, 7'b1100111};
        for (int n = 0; n < 400; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 7)];
            f7 = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'($urandom_range(0, 1));
            rst = ($urandom_range(0, 59) == 0);
            drive($urandom_range(0, 3) != 0, op, f7,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 14) == 0, $urandom_range(0, 5) == 0);
            checks++;
            if (stall_o !== model_stall()) begin
                errors++; $display("FAIL rand_stall n=%0d got=%b exp=%b", n, stall_o, model_stall());
            end
            tick();
            checks++;
            if (dut_vec !== m_vec) begin
                errors++; $display("FAIL rand_bundle n=%0d got=%b exp=%b", n, dut_vec, m_vec);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        m_vec = 13'd0; m_rem = 0;
        rst = 1'b1;
        drive(1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_ld_sd();
        test_hazard();
        test_mul();
        test_flush_mul();
        test_exstall_mul();
        test_jump();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
